anton_neopixel_pixel_encoder: RTL and testbench

- Downstream consumer of the stream-logic counters. It owns the physical NeoPixel data line.
- At each byte start it fetches the addressed pixel byte from the pixel RAM read port with a req/ack handshake, then holds the byte in a shift register.
- It converts each bit into an 8-tick high/low pattern at 6.4 MHz (156.25 ns per tick, 1.25 us per bit) and drives a registered output pin.
- Runs in the clk6_4mhz domain only.

---
 rtl/anton_neopixel_pixel_encoder_pkg.sv | 20 ++
 rtl/anton_neopixel_pattern_gen.sv | 41 ++++
 rtl/anton_neopixel_pixel_encoder.sv | 128 ++++++++++++
 tb/tb_anton_neopixel_pixel_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_pixel_encoder_pkg.sv
// Shared constants, fetch FSM encoding and pattern helper for the NeoPixel pixel encoder.
package anton_neopixel_pixel_encoder_pkg;

   localparam int BUFFER_END_DEFAULT = 511;

   // Tick patterns, MSB is the first tick of a bit period.
   localparam logic [7:0] NEO_PATTERN_0 = 8'b1100_0000;
   localparam logic [7:0] NEO_PATTERN_1 = 8'b1111_1000;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_HAVE = 2'd2
   } fetch_state_e;

   function automatic logic pattern_tick(input logic [7:0] pattern, input logic [2:0] tick_ix);
      return pattern[3'd7 - tick_ix];
   endfunction

endpackage

// File: rtl/anton_neopixel_pattern_gen.sv
// Turns the current bit value and tick index into the registered NeoPixel data line.
module anton_neopixel_pattern_gen
   import anton_neopixel_pixel_encoder_pkg::*;
#(
   parameter logic [7:0] PATTERN_0 = NEO_PATTERN_0,
   parameter logic [7:0] PATTERN_1 = NEO_PATTERN_1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_val,
   input  logic [2:0] bit_pattern_ix,
   input  logic       stream_output,
   output logic       neo_data
);

   logic neo_next_s;

   // Pattern tick selection; line is held low whenever the stream is not transmitting.
   always_comb begin
      neo_next_s = 1'b0;
      if (stream_output) begin
         if (bit_val) begin
            neo_next_s = pattern_tick(PATTERN_1, bit_pattern_ix);
         end else begin
            neo_next_s = pattern_tick(PATTERN_0, bit_pattern_ix);
         end
      end else begin
         neo_next_s = 1'b0;
      end
   end

   // Output pin register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neo_data <= 1'b0;
      end else begin
         neo_data <= neo_next_s;
      end
   end

endmodule

// File: rtl/anton_neopixel_pixel_encoder.sv
// Fetches one pixel byte per byte slot from the pixel RAM and serialises it onto the
// NeoPixel line; a fetch that misses the tick-2 deadline sends zeros and flags underrun.
module anton_neopixel_pixel_encoder
   import anton_neopixel_pixel_encoder_pkg::*;
#(
   parameter int         BUFFER_END  = BUFFER_END_DEFAULT,
   parameter logic [7:0] PATTERN_0   = NEO_PATTERN_0,
   parameter logic [7:0] PATTERN_1   = NEO_PATTERN_1,
   localparam int        BUFFER_BITS = $clog2(BUFFER_END + 1)
)(
   input  logic                   clk6_4mhz,
   input  logic                   rst,
   input  logic                   streamOutput,
   input  logic [2:0]             bitPatternIx,
   input  logic [2:0]             pixelBitIx,
   input  logic [BUFFER_BITS-1:0] pixelIxComb,
   output logic                   ramRdReq,
   output logic [BUFFER_BITS-1:0] ramRdAddr,
   input  logic                   ramRdAck,
   input  logic [7:0]             ramRdData,
   input  logic                   clrUnderrun,
   output logic                   neoData,
   output logic                   underrun,
   output logic                   fetchBusy
);

   fetch_state_e           state_r;
   fetch_state_e           state_next_s;
   logic [7:0]             shift_reg_r;
   logic [7:0]             shift_next_s;
   logic [BUFFER_BITS-1:0] addr_next_s;
   logic                   underrun_set_s;
   logic                   byte_start_s;
   logic                   deadline_s;
   logic                   bit_val_s;

   assign byte_start_s = streamOutput && (pixelBitIx == 3'd0) && (bitPatternIx == 3'd0);
   assign deadline_s   = streamOutput && (pixelBitIx == 3'd0) && (bitPatternIx == 3'd2);

   assign ramRdReq  = (state_r == FETCH_REQ);
   assign fetchBusy = (state_r != FETCH_IDLE);

   // Fetch FSM next-state: byte start always restarts the fetch; a dropped stream discards the byte.
   always_comb begin
      state_next_s   = state_r;
      shift_next_s   = shift_reg_r;
      addr_next_s    = ramRdAddr;
      underrun_set_s = 1'b0;
      if (!streamOutput) begin
         state_next_s = FETCH_IDLE;
         shift_next_s = 8'h00;
      end else if (byte_start_s) begin
         state_next_s = FETCH_REQ;
         addr_next_s  = pixelIxComb;
      end else begin
         case (state_r)
            FETCH_REQ: begin
               if (ramRdAck) begin
                  shift_next_s = ramRdData;
                  state_next_s = FETCH_HAVE;
               end else if (deadline_s) begin
                  shift_next_s   = 8'h00;
                  underrun_set_s = 1'b1;
                  state_next_s   = FETCH_IDLE;
               end else begin
                  state_next_s = FETCH_REQ;
               end
            end
            FETCH_HAVE: state_next_s = FETCH_HAVE;
            FETCH_IDLE: state_next_s = FETCH_IDLE;
            default:    state_next_s = FETCH_IDLE;
         endcase
      end
   end

   // Fetch state, held byte and read address registers.
   always_ff @(posedge clk6_4mhz or posedge rst) begin
      if (rst) begin
         state_r     <= FETCH_IDLE;
         shift_reg_r <= 8'h00;
         ramRdAddr   <= '0;
      end else begin
         state_r     <= state_next_s;
         shift_reg_r <= shift_next_s;
         ramRdAddr   <= addr_next_s;
      end
   end

   // Sticky underrun; a new miss wins over a simultaneous clear.
   always_ff @(posedge clk6_4mhz or posedge rst) begin
      if (rst) begin
         underrun <= 1'b0;
      end else if (underrun_set_s) begin
         underrun <= 1'b1;
      end else if (clrUnderrun) begin
         underrun <= 1'b0;
      end else begin
         underrun <= underrun;
      end
   end

   // While still requesting, the tick-2 decision comes straight from the RAM or is forced to 0.
   always_comb begin
      bit_val_s = 1'b0;
      if (state_r == FETCH_REQ) begin
         if (ramRdAck) begin
            bit_val_s = ramRdData[7];
         end else begin
            bit_val_s = 1'b0;
         end
      end else begin
         bit_val_s = shift_reg_r[3'd7 - pixelBitIx];
      end
   end

   anton_neopixel_pattern_gen #(
      .PATTERN_0 (PATTERN_0),
      .PATTERN_1 (PATTERN_1)
   ) u_pattern_gen (
      .clk            (clk6_4mhz),
      .rst            (rst),
      .bit_val        (bit_val_s),
      .bit_pattern_ix (bitPatternIx),
      .stream_output  (streamOutput),
      .neo_data       (neoData)
   );

endmodule

// File: tb/tb_anton_neopixel_pixel_encoder.sv
// Self-checking bench: drives stream counters and a RAM responder, compares against a byte-level model.
module tb_anton_neopixel_pixel_encoder;

   localparam int BE = 511;
   localparam int BB = $clog2(BE + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          so;
   logic [2:0]    pat;
   logic [2:0]    pix;
   logic [BB-1:0] ixc;
   logic          req;
   logic [BB-1:0] raddr;
   logic          ack;
   logic [7:0]    rdata;
   logic          clr;
   logic          neo;
   logic          und;
   logic          busy;

   int   checks = 0;
   int   errors = 0;
   logic exp_neo = 1'b0;
   logic model_und = 1'b0;

   always #5 clk = ~clk;

   anton_neopixel_pixel_encoder #(.BUFFER_END(BE)) dut (
      .clk6_4mhz    (clk),
      .rst          (rst),
      .streamOutput (so),
      .bitPatternIx (pat),
      .pixelBitIx   (pix),
      .pixelIxComb  (ixc),
      .ramRdReq     (req),
      .ramRdAddr    (raddr),
      .ramRdAck     (ack),
      .ramRdData    (rdata),
      .clrUnderrun  (clr),
      .neoData      (neo),
      .underrun     (und),
      .fetchBusy    (busy)
   );

   // Idle ticks with streamOutput low; clr pulses at tick clr_tick (-1 for none).
   task automatic idle_ticks(input int n, input int clr_tick);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++; if (neo !== exp_neo) begin errors++; $display("FAIL idle_neo tick %0d: got %b want %b", i, neo, exp_neo); end
         checks++; if (req !== 1'b0) begin errors++; $display("FAIL idle_req tick %0d: got %b want 0", i, req); end
         if (i > 0) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy tick %0d: got %b want 0", i, busy); end
         end
         checks++; if (und !== model_und) begin errors++; $display("FAIL idle_underrun tick %0d: got %b want %b", i, und, model_und); end
         so    = 1'b0;
         pat   = 3'($urandom_range(7, 0));
         pix   = 3'($urandom_range(7, 0));
         ixc   = BB'($urandom_range(BE, 0));
         ack   = 1'($urandom_range(1, 0));
         rdata = 8'($urandom);
         clr   = (i == clr_tick);
         exp_neo = 1'b0;
         if (clr) model_und = 1'b0;
      end
   endtask

   // One byte slot: wait_t = ack wait states (0/1, >=2 means never), late_tick = extra ack in bit 0,
   // clr_tick = tick 0..63 for a clear pulse, stop_bit < 8 truncates the slot before that bit.
   task automatic send_byte(input logic [BB-1:0] addr, input logic [7:0] data, input int wait_t,
                            input int late_tick, input int clr_tick, input int stop_bit);
      logic fetched;
      logic bv;
      logic exp_req;
      logic [2:0] bi;
      fetched = (wait_t <= 1);
      for (int k = 0; k < 64; k++) begin
         int b;
         int t;
         b = k / 8;
         t = k % 8;
         if (b >= stop_bit) break;
         @(negedge clk);
         checks++; if (neo !== exp_neo) begin errors++; $display("FAIL neo bit %0d tick %0d: got %b want %b", b, t, neo, exp_neo); end
         exp_req = (b == 0) && ((t == 1) || ((t == 2) && (wait_t >= 1)));
         checks++; if (req !== exp_req) begin errors++; $display("FAIL req bit %0d tick %0d: got %b want %b", b, t, req, exp_req); end
         if (exp_req) begin
            checks++; if (raddr !== addr) begin errors++; $display("FAIL addr tick %0d: got %0d want %0d", t, raddr, addr); end
         end
         if (k > 0) begin
            checks++;
            if (busy !== (fetched || (b == 0 && t <= 2))) begin
               errors++; $display("FAIL busy bit %0d tick %0d: got %b want %b", b, t, busy, fetched || (b == 0 && t <= 2));
            end
         end
         checks++; if (und !== model_und) begin errors++; $display("FAIL underrun bit %0d tick %0d: got %b want %b", b, t, und, model_und); end
         ack   = (b == 0) && (((t == 1) && (wait_t == 0)) || ((t == 2) && (wait_t == 1)) || (t == late_tick));
         rdata = ack ? (fetched ? data : 8'hFF) : 8'($urandom);
         so    = 1'b1;
         pix   = 3'(b);
         pat   = 3'(t);
         ixc   = (t == 0) ? addr : BB'($urandom_range(BE, 0));
         clr   = (k == clr_tick);
         bi    = 3'(b);
         bv    = fetched ? data[3'd7 - bi] : 1'b0;
         exp_neo = (t < (bv ? 5 : 2)) ? 1'b1 : 1'b0;
         if (!fetched && b == 0 && t == 2) model_und = 1'b1;
         else if (clr) model_und = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; so = 1'b0; pat = 3'd0; pix = 3'd0; ixc = '0; ack = 1'b0; rdata = 8'h00; clr = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (neo !== 1'b0) begin errors++; $display("FAIL reset_neo: got %b want 0", neo); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
      checks++; if (raddr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", raddr); end
      checks++; if (und !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", und); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_reset_period();
      idle_ticks(1959, -1);
   endtask

   task automatic test_zero_wait();
      send_byte(BB'(5), 8'hA5, 0, -1, -1, 8);
      idle_ticks(2, -1);
   endtask

   task automatic test_one_wait();
      send_byte(BB'(77), 8'hFF, 1, -1, -1, 8);
      idle_ticks(2, -1);
   endtask

   task automatic test_missed_deadline();
      send_byte(BB'(300), 8'h3C, 2, 4, 2, 8);
      idle_ticks(6, -1);
      send_byte(BB'(12), 8'h81, 0, -1, -1, 8);
      idle_ticks(4, 1);
   endtask

   task automatic test_abort();
      send_byte(BB'(7), 8'hC3, 0, -1, -1, 3);
      idle_ticks(3, -1);
      send_byte(BB'(9), 8'h5A, 0, -1, -1, 8);
   endtask

   task automatic test_back_to_back();
      send_byte(BB'(100), 8'h0F, 1, -1, -1, 8);
      send_byte(BB'(101), 8'hF0, 0, -1, -1, 8);
      send_byte(BB'(102), 8'h99, 1, -1, -1, 8);
      idle_ticks(2, -1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int gap;
         send_byte(BB'($urandom_range(BE, 0)), 8'($urandom), int'($urandom_range(2, 0)),
                   ($urandom_range(3, 0) == 0) ? 4 : -1,
                   ($urandom_range(3, 0) == 0) ? int'($urandom_range(63, 0)) : -1, 8);
         gap = int'($urandom_range(3, 0));
         idle_ticks(gap, ($urandom_range(1, 0) == 1) ? 0 : -1);
      end
   endtask

   task automatic test_async_reset();
      send_byte(BB'(40), 8'h00, 2, -1, -1, 8);
      @(negedge clk);
      so = 1'b1; pix = 3'd0; pat = 3'd0; ixc = BB'(41); ack = 1'b0; clr = 1'b0;
      @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL async_pre_req: got %b want 1", req); end
      checks++; if (neo !== 1'b1) begin errors++; $display("FAIL async_pre_neo: got %b want 1", neo); end
      checks++; if (und !== 1'b1) begin errors++; $display("FAIL async_pre_underrun: got %b want 1", und); end
      pat = 3'd1;
      #2 rst = 1'b1;
      #1;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL async_req: got %b want 0", req); end
      checks++; if (neo !== 1'b0) begin errors++; $display("FAIL async_neo: got %b want 0", neo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
      checks++; if (und !== 1'b0) begin errors++; $display("FAIL async_underrun: got %b want 0", und); end
      @(negedge clk);
      rst = 1'b0; so = 1'b0;
      exp_neo = 1'b0;
      model_und = 1'b0;
      idle_ticks(3, -1);
      send_byte(BB'(200), 8'h6E, 0, -1, -1, 8);
      idle_ticks(2, -1);
   endtask

   initial begin
      test_reset();
      test_reset_period();
      test_zero_wait();
      test_one_wait();
      test_missed_deadline();
      test_abort();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
